// File: rtl/ysyx_lsu_axi_master_pkg.sv
// Shared definitions for the LSU AXI4-Lite master: FSM state encoding and
// AXI response codes. Used by ysyx_lsu_axi_master.
package ysyx_lsu_axi_master_pkg;

    // Master FSM states; a single transaction is in flight at any time.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4
    } lsu_state_e;

    // AXI4-Lite response codes.
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Any response other than OKAY is reported to the LSU as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_lsu_axi_master.sv
// LSU-to-AXI4-Lite bridge. One load or store is in flight at a time; the
// request is captured in IDLE and issued on the AXI channels the next cycle.
// All AXI and LSU outputs come straight from flops.
// Build option: define YSYX_LSU_WR_FIRST_EN to let a pending store win over a
// pending load in IDLE; by default the load wins to keep load latency low.
module ysyx_lsu_axi_master
    import ysyx_lsu_axi_master_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    // LSU load side
    input  logic            rreq,
    input  logic [XLEN-1:0] raddr,
    output logic            rdone,
    output logic [XLEN-1:0] rdata,
    // LSU store side
    input  logic            wreq,
    input  logic [XLEN-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [3:0]      wstrb,
    output logic            wdone,
    output logic            err,
    // AXI4-Lite read address / data
    output logic            arvalid,
    output logic [XLEN-1:0] araddr,
    input  logic            arready,
    input  logic            rvalid,
    input  logic [XLEN-1:0] m_rdata,
    input  logic [1:0]      rresp,
    output logic            rready,
    // AXI4-Lite write address / data / response
    output logic            awvalid,
    output logic [XLEN-1:0] awaddr,
    input  logic            awready,
    output logic            wvalid,
    output logic [XLEN-1:0] m_wdata,
    output logic [3:0]      m_wstrb,
    input  logic            wready,
    input  logic            bvalid,
    input  logic [1:0]      bresp,
    output logic            bready
);

    lsu_state_e      state_q,   state_d;
    logic [XLEN-1:0] addr_q,    addr_d;
    logic [XLEN-1:0] wdata_q,   wdata_d;
    logic [3:0]      wstrb_q,   wstrb_d;
    logic [XLEN-1:0] rdata_q,   rdata_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q,  rready_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q,  wvalid_d;
    logic            bready_q,  bready_d;
    logic            rdone_q,   rdone_d;
    logic            wdone_q,   wdone_d;
    logic            err_q,     err_d;

    logic            accept_s;
    logic            grant_wr_s;
    logic            grant_rd_s;

    // Arbitration between the load and store requesters while idle.
    always_comb begin
        // A done pulse is still visible to the LSU, whose request may not have
        // dropped yet, so nothing is accepted in that cycle.
        accept_s = (state_q == IDLE) && !rdone_q && !wdone_q;
`ifdef YSYX_LSU_WR_FIRST_EN
        grant_wr_s = accept_s && wreq;
        grant_rd_s = accept_s && rreq && !wreq;
`else
        grant_rd_s = accept_s && rreq;
        grant_wr_s = accept_s && wreq && !rreq;
`endif
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        rdone_d   = 1'b0;
        wdone_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_rd_s) begin
                    addr_d    = raddr;
                    arvalid_d = 1'b1;
                    state_d   = RD_A;
                end else if (grant_wr_s) begin
                    addr_d    = waddr;
                    wdata_d   = wdata;
                    wstrb_d   = wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR_A;
                end else begin
                    state_d   = IDLE;
                end
            end
            RD_A: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_D;
                end else begin
                    state_d   = RD_A;
                end
            end
            RD_D: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = m_rdata;
                    rdone_d  = 1'b1;
                    err_d    = resp_is_err(rresp);
                    state_d  = IDLE;
                end else begin
                    state_d  = RD_D;
                end
            end
            WR_A: begin
                // Address and data channels retire independently; both may
                // complete in the same cycle.
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end else begin
                    state_d  = WR_A;
                end
            end
            WR_B: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    wdone_d  = 1'b1;
                    err_d    = resp_is_err(bresp);
                    state_d  = IDLE;
                end else begin
                    state_d  = WR_B;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= {XLEN{1'b0}};
            wdata_q   <= {XLEN{1'b0}};
            wstrb_q   <= 4'b0000;
            rdata_q   <= {XLEN{1'b0}};
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            rdone_q   <= 1'b0;
            wdone_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            rdone_q   <= rdone_d;
            wdone_q   <= wdone_d;
            err_q     <= err_d;
        end
    end

    assign rdone   = rdone_q;
    assign rdata   = rdata_q;
    assign wdone   = wdone_q;
    assign err     = err_q;
    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign rready  = rready_q;
    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign wvalid  = wvalid_q;
    assign m_wdata = wdata_q;
    assign m_wstrb = wstrb_q;
    assign bready  = bready_q;

endmodule
